// File: rtl/q88_power_seq_if.sv
// Handshake and accumulator-register bus for the Q8.8 power sequencer.
// The master side is the controller plus the downstream accumulator register.
interface q88_power_seq_if #(
    parameter int W  = 16,
    parameter int NW = 4
);
    logic          i_start;
    logic          i_clr;
    logic [W-1:0]  i_x;
    logic [NW-1:0] i_n;
    logic [W-1:0]  i_acc_q;
    logic [W-1:0]  o_acc_d;
    logic          o_acc_ld;
    logic          o_acc_sclr;
    logic          o_acc_sset;
    logic          o_busy;
    logic          o_done;
    logic          o_ovf;

    modport slave (
        input  i_start, i_clr, i_x, i_n, i_acc_q,
        output o_acc_d, o_acc_ld, o_acc_sclr, o_acc_sset, o_busy, o_done, o_ovf
    );

    modport master (
        output i_start, i_clr, i_x, i_n, i_acc_q,
        input  o_acc_d, o_acc_ld, o_acc_sclr, o_acc_sset, o_busy, o_done, o_ovf
    );
endinterface

// File: rtl/q88_power_seq.sv
// Computes x^n in unsigned Q8.8 by driving an external accumulator register
// (sset to 1.0, then n saturating multiply-loads) and reading its output back.
module q88_power_seq #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int NW   = 4
) (
    input  logic               clk,
    input  logic               rst,
    q88_power_seq_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, INIT, MULT, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NW-1:0]   r_cnt;
    logic [W-1:0]    r_x;
    logic            r_ovf;
    logic            r_sclr;
    logic [2*W-1:0]  w_prod;
    logic            w_sat;
    logic [W-1:0]    w_mulRes;

    // Any bit above the Q8.8 integer range means the product does not fit.
    assign w_prod   = {{W{1'b0}}, bus.i_acc_q} * {{W{1'b0}}, r_x};
    assign w_sat    = |w_prod[2*W-1:W+FRAC];
    assign w_mulRes = w_sat ? {W{1'b1}} : w_prod[W+FRAC-1:FRAC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.i_clr) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.i_start) w_next = INIT;
                INIT:    w_next = (r_cnt == '0) ? DONE : MULT;
                MULT:    if (r_cnt == NW'(1)) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Operands, iteration count and the sticky overflow flag; clr also arms
    // a one-cycle sync clear of the accumulator for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_x    <= '0;
            r_ovf  <= 1'b0;
            r_sclr <= 1'b0;
        end else begin
            r_sclr <= bus.i_clr;
            if (bus.i_clr) begin
                r_ovf <= 1'b0;
            end else if (r_state == IDLE && bus.i_start) begin
                r_x   <= bus.i_x;
                r_cnt <= bus.i_n;
                r_ovf <= 1'b0;
            end else if (r_state == MULT) begin
                r_cnt <= r_cnt - NW'(1);
                if (w_sat) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.o_acc_d    = '0;
        bus.o_acc_ld   = 1'b0;
        bus.o_acc_sset = 1'b0;
        bus.o_busy     = 1'b0;
        bus.o_done     = 1'b0;
        bus.o_acc_sclr = r_sclr;
        bus.o_ovf      = r_ovf;
        case (r_state)
            INIT: begin
                bus.o_acc_sset = 1'b1;
                bus.o_busy     = 1'b1;
            end
            MULT: begin
                bus.o_acc_ld   = 1'b1;
                bus.o_busy     = 1'b1;
                bus.o_acc_d    = w_mulRes;
            end
            DONE: begin
                bus.o_done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_q88_power_seq.sv
// Directed bench for q88_power_seq with a behavioural accumulator register
// (sclr > sset > ld) closing the feedback loop.
module tb_q88_power_seq;

    logic clk;
    logic rst;

    q88_power_seq_if bus ();

    q88_power_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] accReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 accReg <= 16'h0000;
        else if (bus.o_acc_sclr) accReg <= 16'h0000;
        else if (bus.o_acc_sset) accReg <= 16'h0100;
        else if (bus.o_acc_ld)   accReg <= bus.o_acc_d;
    end

    assign bus.i_acc_q = accReg;

    int          checks;
    int          passes;
    int          overlaps;
    int          doneCyc;
    int          ldCnt;
    int          ssetCnt;
    int          sclrCnt;
    logic [15:0] result;
    logic        ovfAtEnd;
    logic        doneAfter;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // pokeKind 1 re-pulses start (with different x/n) in cycle pokeCycle, 2 pulses clr.
    task automatic applyStimulus(input logic [15:0] xv, input logic [3:0] nv,
                                 input int pokeCycle, input int pokeKind);
        doneCyc   = -1;
        ldCnt     = 0;
        ssetCnt   = 0;
        sclrCnt   = 0;
        doneAfter = 1'b0;
        @(negedge clk);
        bus.i_x     = xv;
        bus.i_n     = nv;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (int'(bus.o_acc_ld) + int'(bus.o_acc_sset) + int'(bus.o_acc_sclr) > 1) overlaps++;
            ldCnt   += int'(bus.o_acc_ld);
            ssetCnt += int'(bus.o_acc_sset);
            sclrCnt += int'(bus.o_acc_sclr);
            if (bus.o_done) begin
                doneCyc  = cyc;
                result   = accReg;
                ovfAtEnd = bus.o_ovf;
                @(posedge clk);
                #1;
                doneAfter = bus.o_done | bus.o_busy;
                break;
            end
            if (cyc == pokeCycle) begin
                if (pokeKind == 1) begin
                    bus.i_start = 1'b1;
                    bus.i_x     = 16'h0300;
                    bus.i_n     = 4'd1;
                end else begin
                    bus.i_clr   = 1'b1;
                end
            end else begin
                bus.i_start = 1'b0;
                bus.i_clr   = 1'b0;
                bus.i_x     = xv;
                bus.i_n     = nv;
            end
            @(posedge clk);
            #1;
        end
        if (doneCyc == -1) begin
            result   = accReg;
            ovfAtEnd = bus.o_ovf;
        end
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        overlaps    = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_clr   = 1'b0;
        bus.i_x     = 16'h0000;
        bus.i_n     = 4'd0;
        #12;
        checkOutput("rstBusy", 32'(bus.o_busy), 32'd0);
        checkOutput("rstDone", 32'(bus.o_done), 32'd0);
        checkOutput("rstOvf", 32'(bus.o_ovf), 32'd0);
        checkOutput("rstCtl", {29'd0, bus.o_acc_ld, bus.o_acc_sclr, bus.o_acc_sset}, 32'd0);
        checkOutput("rstAccD", 32'(bus.o_acc_d), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] T1 x=0x0200 n=3");
        applyStimulus(16'h0200, 4'd3, 0, 0);
        checkOutput("t1Result", 32'(result), 32'h0800);
        checkOutput("t1DoneCyc", doneCyc, 32'd5);
        checkOutput("t1Ovf", 32'(ovfAtEnd), 32'd0);
        checkOutput("t1LdCnt", ldCnt, 32'd3);
        checkOutput("t1SsetCnt", ssetCnt, 32'd1);
        checkOutput("t1DonePulse", 32'(doneAfter), 32'd0);

        $display("[TB] T2 x=0x1234 n=0");
        applyStimulus(16'h1234, 4'd0, 0, 0);
        checkOutput("t2Result", 32'(result), 32'h0100);
        checkOutput("t2DoneCyc", doneCyc, 32'd2);
        checkOutput("t2LdCnt", ldCnt, 32'd0);
        checkOutput("t2SsetCnt", ssetCnt, 32'd1);

        $display("[TB] T3 fractional bases");
        applyStimulus(16'h0180, 4'd2, 0, 0);
        checkOutput("t3aResult", 32'(result), 32'h0240);
        checkOutput("t3aDoneCyc", doneCyc, 32'd4);
        applyStimulus(16'h0001, 4'd2, 0, 0);
        checkOutput("t3bResult", 32'(result), 32'h0000);
        checkOutput("t3bOvf", 32'(ovfAtEnd), 32'd0);

        $display("[TB] T4 saturation");
        applyStimulus(16'h1000, 4'd2, 0, 0);
        checkOutput("t4aResult", 32'(result), 32'hFFFF);
        checkOutput("t4aOvf", 32'(ovfAtEnd), 32'd1);
        checkOutput("t4aOvfSticky", 32'(bus.o_ovf), 32'd1);
        applyStimulus(16'h0100, 4'd1, 0, 0);
        checkOutput("t4bResult", 32'(result), 32'h0100);
        checkOutput("t4bOvf", 32'(ovfAtEnd), 32'd0);
        checkOutput("t4bDoneCyc", doneCyc, 32'd3);

        $display("[TB] T5 start while busy, then clr");
        applyStimulus(16'h0200, 4'd5, 3, 1);
        checkOutput("t5aResult", 32'(result), 32'h2000);
        checkOutput("t5aDoneCyc", doneCyc, 32'd7);
        applyStimulus(16'h1000, 4'd5, 4, 2);
        checkOutput("t5bNoDone", doneCyc, 32'hFFFF_FFFF);
        checkOutput("t5bSclrCnt", sclrCnt, 32'd1);
        checkOutput("t5bLdCnt", ldCnt, 32'd3);
        checkOutput("t5bResult", 32'(result), 32'h0000);
        checkOutput("t5bOvf", 32'(ovfAtEnd), 32'd0);
        checkOutput("t5bBusy", 32'(bus.o_busy), 32'd0);

        $display("[TB] T6 async reset mid-multiply");
        @(negedge clk);
        bus.i_x     = 16'h0200;
        bus.i_n     = 4'd5;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("t6PreLd", 32'(bus.o_acc_ld), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6Busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t6Ctl", {29'd0, bus.o_acc_ld, bus.o_acc_sclr, bus.o_acc_sset}, 32'd0);
        checkOutput("t6AccD", 32'(bus.o_acc_d), 32'd0);
        checkOutput("t6Done", 32'(bus.o_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'h0300, 4'd2, 0, 0);
        checkOutput("t6Result", 32'(result), 32'h0900);
        checkOutput("t6DoneCyc", doneCyc, 32'd4);

        checkOutput("ctlOverlap", overlaps, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
